vga_sink: RTL and testbench
===========================

VGA_SINK -- requirements
Module: vga_sink

Interface
REQ-001 clk  in  1  system clock, 50 MHz; same clock as the VGA source.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 chipselect  in  1  Avalon slave select.
REQ-004 read  in  1  Avalon read strobe.
REQ-005 write  in  1  Avalon write strobe.
REQ-006 address  in  4  register index, map per REQ-020.
REQ-007 writedata  in  8  write data.
REQ-008 readdata  out  8  read data, registered.
REQ-009 VGA_R, VGA_G, VGA_B  in  8 each  pixel colour under test.
REQ-010 VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n  in  1 each  VGA timing under test; HS/VS active-low.

Function
REQ-011 SHALL register all VGA inputs once on clk; all detection below uses registered samples plus one previous-sample register.
REQ-012 SHALL define pixel strobe = VGA_CLK sample 0 -> 1 with VGA_BLANK_n sample high; line start = HS 1 -> 0; frame start = VS 1 -> 0.
REQ-013 SHALL count strobes per line (11 bit); on line start, latch a nonzero count as frame hpix and clear the counter.
REQ-014 SHALL count clk cycles between consecutive line starts (11 bit, saturating at 2047); latch as frame line_clks.
REQ-015 SHALL count lines containing at least one strobe (10 bit, saturating at 1023); latch as frame vlines at frame start, then clear.
REQ-016 SHALL implement FSM SEARCH=0, MEASURE=1, LOCKED=2. SEARCH -> MEASURE on first frame start (partial frame discarded). MEASURE -> LOCKED on next frame start, publishing frame hpix/vlines/line_clks.
REQ-017 LOCKED, at frame start: all three frame values equal to published -> stay. Any mismatch -> errcnt +1 (saturating at 255), err_sticky=1, publish new values, go to MEASURE.
REQ-018 Any state: 2^20 clk cycles with no frame start -> SEARCH; published values retained.
REQ-019 SHALL increment 8-bit wrapping frames counter on every frame start in every state.
REQ-020 Register map, addr: content.
 0 STATUS R {4'b0, err_sticky, locked, state[1:0]}; any write clears err_sticky.
 1/2 HPIX lo / {5'b0, hi[10:8]}.
 3/4 VLINES lo / {6'b0, hi[9:8]}.
 5/6 LINE_CLKS lo / {5'b0, hi[10:8]}.
 7 FRAMES. 8 ERRCNT.
 9/10/11 PROBE_R/G/B.
 12/13 PROBE_X lo / hi[1:0], R/W. 14/15 PROBE_Y lo / hi[1:0], R/W.
 Writes to read-only addresses are ignored.
REQ-021 readdata SHALL be valid the cycle after chipselect & read; it holds its value otherwise.
REQ-022 locked SHALL be 1 iff state == LOCKED.
REQ-023 Error set and err_sticky clear in the same cycle: set wins.
REQ-024 Published values SHALL change only at frame start.

Reset
REQ-025 On reset: state SEARCH; all counters, published values, errcnt, frames, err_sticky, probe colour registers, probe coordinates and readdata = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; measurement restarts from SEARCH.

Configuration
REQ-027 Macro VGA_SINK_PROBE_EN defined: 10-bit x counter (strobes since line start) and y counter (active lines since frame start) are compiled in. On a strobe with x == PROBE_X and y == PROBE_Y, RGB is captured into PROBE_R/G/B.
REQ-028 Macro VGA_SINK_PROBE_EN undefined: addresses 9-15 read 0, writes to them are ignored, and no probe logic is present.

Verification
REQ-029 Nominal source timing (1600 clk/line, 1280 active clk, 525 lines, 480 active, VS low on lines 490-491) for 3 frames -> STATUS=0x06; HPIX=640, VLINES=480, LINE_CLKS=1600; ERRCNT=0.
REQ-030 Locked, then one frame with 479 active lines -> at next frame start ERRCNT=1, STATUS=0x09, VLINES=479; after one more 480-line frame: STATUS=0x0E, VLINES=480.
REQ-031 Write STATUS while err_sticky=1 on a quiet cycle -> bit3 clears. Same write on a cycle where a mismatch is detected -> bit3 stays 1.
REQ-032 VS held high for 2^20 clks while LOCKED -> STATUS[1:0]=0, HPIX retained at 640.
REQ-033 (PROBE_EN) PROBE_X=100, PROBE_Y=10; source drives RGB=0x12,0x34,0x56 only at that pixel -> PROBE_R/G/B read 0x12/0x34/0x56. Without macro -> address 9 reads 0.
REQ-034 Reset pulse mid-frame while LOCKED -> all registers 0; re-locks after 2 frame starts.

Source files
------------

// File: rtl/vga_sink.sv
// vga_sink: measures VGA timing from a same-clock source and exposes it as Avalon registers.
// Defining VGA_SINK_PROBE_EN adds a pixel colour probe at a programmable x/y (addresses 9-15).
module vga_sink #(
    parameter int TO_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       read,
    input  logic       write,
    input  logic [3:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       VGA_CLK,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_BLANK_n
);
    typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;
    state_e state_q, state_d;
    logic vclk_q, hs_q, vs_q, blank_q, vclk_p_q, hs_p_q, vs_p_q;
    logic [10:0] hcnt_q, hcnt_d, lclk_q, lclk_d, f_hpix_q, f_hpix_d, f_lclk_q, f_lclk_d;
    logic [10:0] p_hpix_q, p_hpix_d, p_lclk_q, p_lclk_d;
    logic [9:0] vcnt_q, vcnt_d, vsum, p_vl_q, p_vl_d;
    logic has_px_q, has_px_d, sticky_q, sticky_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic [7:0] frames_q, frames_d, errcnt_q, errcnt_d, readdata_q, rd_mux;
    logic strobe, line_start, frame_start, match, err, publish, wr, rd;

    assign strobe      = vclk_q & ~vclk_p_q & blank_q;
    assign line_start  = hs_p_q & ~hs_q;
    assign frame_start = vs_p_q & ~vs_q;
    assign wr          = chipselect & write;
    assign rd          = chipselect & read;
    assign readdata    = readdata_q;

    // Frame values use the _d forms so a line ending on the frame-start cycle is included.
    always_comb begin
        hcnt_d   = line_start ? {10'd0, strobe} : hcnt_q + {10'd0, strobe};
        f_hpix_d = line_start && |hcnt_q ? hcnt_q : f_hpix_q;
        lclk_d   = line_start ? 11'd1 : lclk_q + {10'd0, ~&lclk_q};
        f_lclk_d = line_start ? lclk_q : f_lclk_q;
        has_px_d = line_start ? strobe : has_px_q | strobe;
        vsum     = vcnt_q + {9'd0, line_start & has_px_q & ~&vcnt_q};
        vcnt_d   = frame_start ? 10'd0 : vsum;
        match    = f_hpix_d == p_hpix_q && vsum == p_vl_q && f_lclk_d == p_lclk_q;
        to_d     = frame_start || &to_q ? '0 : to_q + TO_BITS'(1);
        p_hpix_d = publish ? f_hpix_d : p_hpix_q;
        p_vl_d   = publish ? vsum : p_vl_q;
        p_lclk_d = publish ? f_lclk_d : p_lclk_q;
        frames_d = frames_q + {7'd0, frame_start};
        errcnt_d = errcnt_q + {7'd0, err & ~&errcnt_q};
        sticky_d = err | (sticky_q & ~(wr && address == 4'd0));
    end

    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        publish = 1'b0;
        if (frame_start) begin
            case (state_q)
                SEARCH:  state_d = MEASURE;
                MEASURE: begin
                    state_d = LOCKED;
                    publish = 1'b1;
                end
                LOCKED: if (!match) begin
                    state_d = MEASURE;
                    err     = 1'b1;
                    publish = 1'b1;
                end
                default: state_d = SEARCH;
            endcase
        end else if (&to_q) begin
            state_d = SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {vclk_q, hs_q, vs_q, blank_q, vclk_p_q, hs_p_q, vs_p_q} <= '0;
            state_q <= SEARCH;
            {hcnt_q, lclk_q, f_hpix_q, f_lclk_q, p_hpix_q, p_lclk_q} <= '0;
            {vcnt_q, p_vl_q} <= '0;
            {has_px_q, sticky_q} <= '0;
            to_q <= '0;
            {frames_q, errcnt_q, readdata_q} <= '0;
        end else begin
            {vclk_q, hs_q, vs_q, blank_q} <= {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n};
            {vclk_p_q, hs_p_q, vs_p_q} <= {vclk_q, hs_q, vs_q};
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            lclk_q     <= lclk_d;
            f_hpix_q   <= f_hpix_d;
            f_lclk_q   <= f_lclk_d;
            p_hpix_q   <= p_hpix_d;
            p_lclk_q   <= p_lclk_d;
            vcnt_q     <= vcnt_d;
            p_vl_q     <= p_vl_d;
            has_px_q   <= has_px_d;
            sticky_q   <= sticky_d;
            to_q       <= to_d;
            frames_q   <= frames_d;
            errcnt_q   <= errcnt_d;
            readdata_q <= rd ? rd_mux : readdata_q;
        end
    end

`ifdef VGA_SINK_PROBE_EN
    logic [7:0] r_q, g_q, b_q, pr_q, pg_q, pb_q;
    logic [9:0] px_q, py_q;
    logic hit;
    // x is the strobe count so far in the line, y the active-line count so far in the frame.
    assign hit = strobe && hcnt_q[9:0] == px_q && vcnt_q == py_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_q, g_q, b_q, pr_q, pg_q, pb_q} <= '0;
            {px_q, py_q} <= '0;
        end else begin
            {r_q, g_q, b_q} <= {VGA_R, VGA_G, VGA_B};
            if (hit) {pr_q, pg_q, pb_q} <= {r_q, g_q, b_q};
            if (wr && address == 4'd12) px_q[7:0] <= writedata;
            if (wr && address == 4'd13) px_q[9:8] <= writedata[1:0];
            if (wr && address == 4'd14) py_q[7:0] <= writedata;
            if (wr && address == 4'd15) py_q[9:8] <= writedata[1:0];
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{VGA_R, VGA_G, VGA_B, writedata};
`endif

    always_comb begin
        rd_mux = 8'd0;
        case (address)
            4'd0:  rd_mux = {4'd0, sticky_q, state_q == LOCKED, state_q};
            4'd1:  rd_mux = p_hpix_q[7:0];
            4'd2:  rd_mux = {5'd0, p_hpix_q[10:8]};
            4'd3:  rd_mux = p_vl_q[7:0];
            4'd4:  rd_mux = {6'd0, p_vl_q[9:8]};
            4'd5:  rd_mux = p_lclk_q[7:0];
            4'd6:  rd_mux = {5'd0, p_lclk_q[10:8]};
            4'd7:  rd_mux = frames_q;
            4'd8:  rd_mux = errcnt_q;
`ifdef VGA_SINK_PROBE_EN
            4'd9:  rd_mux = pr_q;
            4'd10: rd_mux = pg_q;
            4'd11: rd_mux = pb_q;
            4'd12: rd_mux = px_q[7:0];
            4'd13: rd_mux = {6'd0, px_q[9:8]};
            4'd14: rd_mux = py_q[7:0];
            4'd15: rd_mux = {6'd0, py_q[9:8]};
`endif
            default: rd_mux = 8'd0;
        endcase
    end
endmodule

// File: tb/tb_vga_sink.sv
// tb_vga_sink: scaled VGA source (40 clk/line, 24 active clk, 12 lines, 8 active, VS low on lines 9-10)
// with a short timeout; register reads are scored by a monitor against queued expected values.
module tb_vga_sink;
    logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [3:0] address = 4'd0;
    logic [7:0] writedata = 8'd0, readdata;
    logic [7:0] VGA_R = 8'd0, VGA_G = 8'd0, VGA_B = 8'd0;
    logic VGA_CLK = 1'b0, VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK_n = 1'b0;
    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    string nm_q[$];
    bit src_en = 1'b0, vs_en = 1'b1;
    int act_lines = 8, h = 0, v = 0, drv_h = 0, drv_v = 0, src_frames = 0;
`ifdef VGA_SINK_PROBE_EN
    localparam bit PROBE = 1'b1;
`else
    localparam bit PROBE = 1'b0;
`endif

    vga_sink #(.TO_BITS(12)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n)
    );

    always #10 clk = ~clk;

    // Pixel clock is clk/2, so 24 active clocks give 12 pixels; probe colour only at x=3, y=2.
    initial forever begin
        @(negedge clk);
        if (src_en) begin
            drv_h = h;
            drv_v = v;
            VGA_CLK = h[0];
            VGA_BLANK_n = h < 24 && v < act_lines;
            VGA_HS = !(h >= 30 && h < 34);
            VGA_VS = !(vs_en && (v == 9 || v == 10));
            {VGA_R, VGA_G, VGA_B} = (h == 7 && v == 2) ? 24'h123456 : 24'h000000;
            h++;
            if (h == 40) begin
                h = 0;
                v++;
                if (v == 12) begin
                    v = 0;
                    src_frames++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (chipselect && read) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: readdata=0x%02h with no expected value", readdata);
            end else begin
                logic [7:0] e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (readdata !== e) begin
                    failures++;
                    $display("FAIL %s: readdata=0x%02h expected=0x%02h", n, readdata, e);
                end
            end
        end
    end

    task automatic rd_reg(input logic [3:0] a, input logic [7:0] e, input string n);
        @(negedge clk);
        chipselect = 1'b1;
        read = 1'b1;
        address = a;
        exp_q.push_back(e);
        nm_q.push_back(n);
        @(negedge clk);
        chipselect = 1'b0;
        read = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write = 1'b1;
        address = a;
        writedata = d;
        @(negedge clk);
        chipselect = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (src_frames < n && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (src_frames < n) begin
            checks++;
            failures++;
            $display("FAIL wait_frames: frames=%0d required=%0d", src_frames, n);
        end
    endtask

    task automatic wait_pos(input int vv, input int hh);
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!(drv_v == vv && drv_h == hh) && k < 1000);
        if (!(drv_v == vv && drv_h == hh)) begin
            checks++;
            failures++;
            $display("FAIL wait_pos: line=%0d required=%0d", drv_v, vv);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        rd_reg(4'd0, 8'h00, "rst_status");
        rd_reg(4'd1, 8'h00, "rst_hpix");
        rd_reg(4'd3, 8'h00, "rst_vlines");
        rd_reg(4'd5, 8'h00, "rst_line_clks");
        rd_reg(4'd7, 8'h00, "rst_frames");
        rd_reg(4'd8, 8'h00, "rst_errcnt");
        rd_reg(4'd9, 8'h00, "rst_probe_r");
        wr_reg(4'd12, 8'd3);
        wr_reg(4'd13, 8'd0);
        wr_reg(4'd14, 8'd2);
        wr_reg(4'd15, 8'd0);
        wr_reg(4'd7, 8'h55);
        rd_reg(4'd12, PROBE ? 8'd3 : 8'd0, "probe_x");
        rd_reg(4'd14, PROBE ? 8'd2 : 8'd0, "probe_y");
        rd_reg(4'd7, 8'h00, "frames_ro");
        src_en = 1'b1;
        wait_frames(3);
        rd_reg(4'd0, 8'h06, "lock_status");
        rd_reg(4'd1, 8'h0C, "hpix_lo");
        rd_reg(4'd2, 8'h00, "hpix_hi");
        rd_reg(4'd3, 8'h08, "vlines_lo");
        rd_reg(4'd4, 8'h00, "vlines_hi");
        rd_reg(4'd5, 8'h28, "line_clks_lo");
        rd_reg(4'd6, 8'h00, "line_clks_hi");
        rd_reg(4'd7, 8'h03, "frames");
        rd_reg(4'd8, 8'h00, "errcnt");
        rd_reg(4'd9, PROBE ? 8'h12 : 8'h00, "probe_r");
        rd_reg(4'd10, PROBE ? 8'h34 : 8'h00, "probe_g");
        rd_reg(4'd11, PROBE ? 8'h56 : 8'h00, "probe_b");
        act_lines = 7;
        wait_frames(4);
        rd_reg(4'd8, 8'h01, "err_errcnt");
        rd_reg(4'd0, 8'h09, "err_status");
        rd_reg(4'd3, 8'h07, "err_vlines");
        act_lines = 8;
        wait_frames(5);
        rd_reg(4'd0, 8'h0E, "relock_status");
        rd_reg(4'd3, 8'h08, "relock_vlines");
        rd_reg(4'd8, 8'h01, "relock_errcnt");
        wr_reg(4'd0, 8'h00);
        rd_reg(4'd0, 8'h06, "sticky_clear");
        act_lines = 7;
        wait_pos(9, 0);
        wr_reg(4'd0, 8'h00);
        rd_reg(4'd0, 8'h09, "sticky_set_wins");
        rd_reg(4'd8, 8'h02, "errcnt_2");
        act_lines = 8;
        wait_frames(7);
        rd_reg(4'd0, 8'h0E, "relock2_status");
        rd_reg(4'd7, 8'h07, "frames_7");
        vs_en = 1'b0;
        wait_frames(17);
        rd_reg(4'd0, 8'h08, "timeout_status");
        rd_reg(4'd1, 8'h0C, "timeout_hpix");
        rd_reg(4'd7, 8'h07, "timeout_frames");
        vs_en = 1'b1;
        wait_frames(19);
        rd_reg(4'd0, 8'h0E, "resume_status");
        rd_reg(4'd7, 8'h09, "resume_frames");
        wait_pos(3, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_reg(4'd0, 8'h00, "mid_rst_status");
        rd_reg(4'd1, 8'h00, "mid_rst_hpix");
        rd_reg(4'd3, 8'h00, "mid_rst_vlines");
        rd_reg(4'd5, 8'h00, "mid_rst_line_clks");
        rd_reg(4'd7, 8'h00, "mid_rst_frames");
        rd_reg(4'd8, 8'h00, "mid_rst_errcnt");
        rd_reg(4'd9, 8'h00, "mid_rst_probe_r");
        rd_reg(4'd12, 8'h00, "mid_rst_probe_x");
        wait_frames(21);
        rd_reg(4'd0, 8'h06, "post_rst_status");
        rd_reg(4'd7, 8'h02, "post_rst_frames");
        rd_reg(4'd1, 8'h0C, "post_rst_hpix");
        rd_reg(4'd3, 8'h08, "post_rst_vlines");
        rd_reg(4'd5, 8'h28, "post_rst_line_clks");
        rd_reg(4'd8, 8'h00, "post_rst_errcnt");
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
